// File: rtl/mem_responder_if.sv
// mem_responder_if: MOV/MOC memory handshake bundle between the control unit and the memory.
//   MOV      - memory operation valid (control unit -> memory)
//   RW       - 1 = read, 0 = write
//   typeData - access size: 00 byte, 01 halfword, 10 word, 11 illegal
//   Address  - byte address (MAR), only [7:0] used by the memory
//   DataIn   - write data; byte in [7:0], halfword in [15:0]
//   DataOut  - registered read data, zero-extended (memory -> control unit)
//   MOC      - memory operation complete
//   ERR      - access rejected, valid while MOC=1
// Modports: master = control unit side, slave = memory side.
interface mem_responder_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  typeData;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        ERR;

  modport master (
    output MOV,
    output RW,
    output typeData,
    output Address,
    output DataIn,
    input  DataOut,
    input  MOC,
    input  ERR
  );

  modport slave (
    input  MOV,
    input  RW,
    input  typeData,
    input  Address,
    input  DataIn,
    output DataOut,
    output MOC,
    output ERR
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: byte-addressable big-endian memory acting as the responder on the MOV/MOC
// handshake. A request is captured in IDLE, delayed by WAIT_CYCLES wait states, performed on
// entry to DONE, and MOC is held until MOV is released. Misaligned halfword/word accesses and
// typeData=11 are rejected with ERR (no write, DataOut unchanged) but still complete normally.
//
// Ports:
//   CLK - rising-edge clock
//   CLR - synchronous active-high reset (does not clear storage)
//   bus - mem_responder_if.slave: MOV, RW, typeData, Address, DataIn in; DataOut, MOC, ERR out
//
// Parameters:
//   WAIT_CYCLES - wait states between capture and access (0..15)
//   DEPTH       - bytes of storage; byte offsets wrap modulo DEPTH
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH       = 256
) (
  input  logic           CLK,
  input  logic           CLR,
  mem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  // Storage. Written from a plain always block so benches may initialise it hierarchically.
  logic [7:0] mem [0:DEPTH-1];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] dout_q, dout_d;

  // Latched request
  logic [7:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  td_q, td_d;
  logic [31:0] din_q, din_d;

  // Effective request: live inputs while IDLE (needed when WAIT_CYCLES=0), latched otherwise
  logic [7:0]  req_addr;
  logic        req_rw;
  logic [1:0]  req_td;
  logic [31:0] req_din;

  logic          access;
  logic          bad;
  logic          wr_en;
  logic [31:0]   rd_data;
  logic [AW-1:0] idx0, idx1, idx2, idx3;

  logic unused_addr;
  assign unused_addr = ^bus.Address[31:8];

  function automatic logic [AW-1:0] wrap_idx(input logic [7:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return AW'(sum % DEPTH);
  endfunction

  always_comb begin
    if (state_q == StIdle) begin
      req_addr = bus.Address[7:0];
      req_rw   = bus.RW;
      req_td   = bus.typeData;
      req_din  = bus.DataIn;
    end else begin
      req_addr = addr_q;
      req_rw   = rw_q;
      req_td   = td_q;
      req_din  = din_q;
    end
  end

  assign idx0 = wrap_idx(req_addr, 0);
  assign idx1 = wrap_idx(req_addr, 1);
  assign idx2 = wrap_idx(req_addr, 2);
  assign idx3 = wrap_idx(req_addr, 3);

  // Alignment / size legality
  always_comb begin
    case (req_td)
      SzByte:  bad = 1'b0;
      SzHalf:  bad = req_addr[0];
      SzWord:  bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  // Big-endian assembly: lowest address lands in the most significant used byte
  always_comb begin
    case (req_td)
      SzByte:  rd_data = {24'h0, mem[idx0]};
      SzHalf:  rd_data = {16'h0, mem[idx0], mem[idx1]};
      SzWord:  rd_data = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
      default: rd_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    td_d    = td_q;
    din_d   = din_q;
    access  = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.MOV) begin
          addr_d = bus.Address[7:0];
          rw_d   = bus.RW;
          td_d   = bus.typeData;
          din_d  = bus.DataIn;
          if (WAIT_CYCLES == 0) begin
            state_d = StDone;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        // Dropping MOV abandons the request before any side effect
        if (!bus.MOV) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = StDone;
          cnt_d   = 4'd0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (!bus.MOV) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
        err_d   = 1'b0;
      end
    endcase

    if (access) begin
      err_d = bad;
      if (!bad && req_rw) begin
        dout_d = rd_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      dout_q  <= 32'h0;
      addr_q  <= 8'h0;
      rw_q    <= 1'b0;
      td_q    <= 2'b00;
      din_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      td_q    <= td_d;
      din_q   <= din_d;
    end
  end

  // Reset wins over any access completing on the same edge
  assign wr_en = access && !req_rw && !bad && !CLR;

  always @(posedge CLK) begin
    if (wr_en) begin
      case (req_td)
        SzByte: begin
          mem[idx0] <= req_din[7:0];
        end
        SzHalf: begin
          mem[idx0] <= req_din[15:8];
          mem[idx1] <= req_din[7:0];
        end
        SzWord: begin
          mem[idx0] <= req_din[31:24];
          mem[idx1] <= req_din[23:16];
          mem[idx2] <= req_din[15:8];
          mem[idx3] <= req_din[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.MOC     = (state_q == StDone);
  assign bus.ERR     = err_q;
  assign bus.DataOut = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus randomized checks of mem_responder against a byte-array
// reference model. Instance A uses two wait states, instance B none.
module tb_mem_responder;

  localparam int unsigned WcA = 2;
  localparam int unsigned WcB = 0;

  logic CLK = 1'b0;
  logic clr_a;
  logic clr_b;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(
    .WAIT_CYCLES (WcA),
    .DEPTH       (256)
  ) u_dut_a (
    .CLK (CLK),
    .CLR (clr_a),
    .bus (bus_a)
  );

  mem_responder #(
    .WAIT_CYCLES (WcB),
    .DEPTH       (256)
  ) u_dut_b (
    .CLK (CLK),
    .CLR (clr_b),
    .bus (bus_b)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: memory image and last successful read per instance
  logic [7:0]  mm      [2][256];
  logic [31:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int w, input logic mov, input logic rw, input logic [1:0] td,
                         input logic [31:0] addr, input logic [31:0] din);
    if (w == 0) begin
      bus_a.MOV = mov; bus_a.RW = rw; bus_a.typeData = td;
      bus_a.Address = addr; bus_a.DataIn = din;
    end else begin
      bus_b.MOV = mov; bus_b.RW = rw; bus_b.typeData = td;
      bus_b.Address = addr; bus_b.DataIn = din;
    end
  endtask

  function automatic logic moc_of(input int w);
    return (w == 0) ? bus_a.MOC : bus_b.MOC;
  endfunction

  function automatic logic err_of(input int w);
    return (w == 0) ? bus_a.ERR : bus_b.ERR;
  endfunction

  function automatic logic [31:0] dout_of(input int w);
    return (w == 0) ? bus_a.DataOut : bus_b.DataOut;
  endfunction

  task automatic preload(input int w, input int idx, input logic [7:0] v);
    if (w == 0) u_dut_a.mem[idx] = v;
    else        u_dut_b.mem[idx] = v;
    mm[w][idx] = v;
  endtask

  // Apply one access to the model; returns expected ERR and DataOut
  task automatic model_access(input int w, input logic rw, input logic [1:0] td,
                              input logic [7:0] addr, input logic [31:0] din,
                              output logic exp_err, output logic [31:0] exp_dout);
    int n;
    logic [31:0] v;
    n = (td == 2'b00) ? 1 : (td == 2'b01) ? 2 : 4;
    exp_err = (td == 2'b11) || (td == 2'b01 && addr[0]) || (td == 2'b10 && addr[1:0] != 2'b00);
    if (!exp_err) begin
      if (rw) begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(mm[w][(int'(addr) + k) % 256]);
        last_rd[w] = v;
      end else begin
        for (int k = 0; k < n; k++) mm[w][(int'(addr) + k) % 256] = din[8*(n-1-k) +: 8];
      end
    end
    exp_dout = last_rd[w];
  endtask

  // Full handshake: raise MOV at a falling edge, scramble inputs after capture, check latency,
  // results, optional hold in DONE, and release.
  task automatic do_req(input int w, input logic rw, input logic [1:0] td, input logic [7:0] addr,
                        input logic [31:0] din, input int hold);
    logic        exp_err;
    logic [31:0] exp_d;
    int          n;
    int          lat_exp;
    model_access(w, rw, td, addr, din, exp_err, exp_d);
    lat_exp = int'((w == 0) ? WcA : WcB) + 1;
    set_req(w, 1'b1, rw, td, {24'($urandom), addr}, din);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 1) set_req(w, 1'b1, 1'($urandom), 2'($urandom), $urandom, $urandom);
    end while (moc_of(w) !== 1'b1 && n < 40);
    chk("latency", 32'(n), 32'(lat_exp));
    chk("moc_rise", 32'(moc_of(w)), 32'd1);
    chk("err", 32'(err_of(w)), 32'(exp_err));
    chk("dataout", dout_of(w), exp_d);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("hold_moc", 32'(moc_of(w)), 32'd1);
      chk("hold_dataout", dout_of(w), exp_d);
    end
    set_req(w, 1'b0, 1'($urandom), 2'($urandom), $urandom, $urandom);
    @(negedge CLK);
    chk("moc_fall", 32'(moc_of(w)), 32'd0);
    chk("err_clear", 32'(err_of(w)), 32'd0);
    chk("dataout_keep", dout_of(w), exp_d);
  endtask

  initial begin
    clr_a = 1'b1;
    clr_b = 1'b1;
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 256; i++) preload(w, i, 8'($urandom));
    end
    preload(0, 4, 8'hE3);
    preload(0, 5, 8'hA0);
    preload(0, 6, 8'h10);
    preload(0, 7, 8'h05);
    preload(0, 8, 8'h00);
    preload(1, 0, 8'h7F);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    repeat (2) @(negedge CLK);
    chk("rst_moc_a", 32'(bus_a.MOC), 32'd0);
    chk("rst_err_a", 32'(bus_a.ERR), 32'd0);
    chk("rst_dout_a", bus_a.DataOut, 32'h0);
    chk("rst_moc_b", 32'(bus_b.MOC), 32'd0);
    chk("rst_dout_b", bus_b.DataOut, 32'h0);
    clr_a = 1'b0;
    clr_b = 1'b0;

    // Word read
    do_req(0, 1'b1, 2'b10, 8'd4, 32'h0, 0);
    chk("word_read_const", bus_a.DataOut, 32'hE3A01005);

    // Byte and halfword writes, then word read over them
    do_req(0, 1'b0, 2'b00, 8'd9, 32'h5555_55AB, 0);
    do_req(0, 1'b0, 2'b01, 8'd10, 32'h6666_1234, 0);
    do_req(0, 1'b1, 2'b10, 8'd8, 32'h0, 0);
    chk("mixed_read_const", bus_a.DataOut, 32'h00AB1234);

    // Misaligned and illegal accesses
    do_req(0, 1'b1, 2'b10, 8'd6, 32'h0, 0);
    chk("misaligned_keep", bus_a.DataOut, 32'h00AB1234);
    do_req(0, 1'b0, 2'b01, 8'd3, 32'h0000_BEEF, 0);
    do_req(0, 1'b1, 2'b11, 8'd0, 32'h0, 0);
    do_req(0, 1'b0, 2'b11, 8'd32, 32'hFFFF_FFFF, 0);

    // Abort: MOV dropped after one wait edge
    set_req(0, 1'b1, 1'b0, 2'b10, 32'd12, 32'hDEAD_BEEF);
    repeat (2) @(negedge CLK);
    chk("abort_moc_wait", 32'(bus_a.MOC), 32'd0);
    set_req(0, 1'b0, 1'b0, 2'b10, 32'd12, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("abort_moc_idle", 32'(bus_a.MOC), 32'd0);
    end

    // Reset during WAIT
    set_req(0, 1'b1, 1'b0, 2'b10, 32'd12, 32'hCAFE_F00D);
    @(negedge CLK);
    clr_a = 1'b1;
    @(negedge CLK);
    chk("rstwait_moc", 32'(bus_a.MOC), 32'd0);
    chk("rstwait_err", 32'(bus_a.ERR), 32'd0);
    chk("rstwait_dout", bus_a.DataOut, 32'h0);
    last_rd[0] = 32'h0;
    clr_a = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge CLK);
    chk("rstwait_idle_moc", 32'(bus_a.MOC), 32'd0);

    // CLR and MOV together: request must not be captured at the reset edge
    clr_a = 1'b1;
    set_req(0, 1'b1, 1'b1, 2'b10, 32'd4, 32'h0);
    @(negedge CLK);
    clr_a = 1'b0;
    do_req(0, 1'b1, 2'b10, 8'd4, 32'h0, 0);

    // Hold MOV in DONE for five extra cycles, then back-to-back requests
    do_req(0, 1'b1, 2'b10, 8'd8, 32'h0, 5);
    do_req(0, 1'b0, 2'b10, 8'd16, 32'h0102_0304, 3);
    do_req(0, 1'b1, 2'b01, 8'd18, 32'h0, 0);

    // Zero-wait instance
    do_req(1, 1'b1, 2'b00, 8'd0, 32'h0, 0);
    chk("zero_wait_byte", bus_b.DataOut, 32'h0000_007F);

    // Randomized traffic in a small window so reads hit earlier writes
    for (int i = 0; i < 40; i++) begin
      do_req(0, 1'($urandom), 2'($urandom), 8'($urandom_range(0, 63)), $urandom,
             int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 20; i++) begin
      do_req(1, 1'($urandom), 2'($urandom), 8'($urandom_range(0, 63)), $urandom,
             int'($urandom_range(0, 2)));
    end

    // Storage must match the model byte for byte
    for (int i = 0; i < 256; i++) begin
      chk("mem_a", 32'(u_dut_a.mem[i]), 32'(mm[0][i]));
      chk("mem_b", 32'(u_dut_b.mem[i]), 32'(mm[1][i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
